uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Transmit-side buffer between the core's memory-mapped UART store path and the `uart` transmitter's `send`/`tx_data`/`busy` handshake. Bytes written by the CPU queue in a small FIFO. A launch state machine presents them one at a time to the transmitter, which runs on the slow baud `tick` clock. The block synchronises `busy` into `clk`, holds each byte stable until the transmitter acknowledges it, and reports fill level and error conditions to the CPU.

## Interface
- `DEPTH`, 16, FIFO entries; must be a power of two, ≥ 2
- `AW`, 4, log2(DEPTH)
- `LAUNCH_TO`, 4096, `clk` cycles to wait for `busy` to rise after `send` before abandoning the byte
- `clk` input 1, system clock
- `reset` input 1, asynchronous, active-low reset
- `wr_en` input 1, CPU write strobe, one byte per asserted cycle
- `wr_data` input 8, byte to enqueue
- `clr_err` input 1, clears `overflow` and `timeout` sticky flags
- `uart_busy` input 1, transmitter busy, `tick` domain (asynchronous to `clk`)
- `uart_send` output 1, send request to transmitter
- `uart_data` output 8, byte presented to transmitter
- `full` output 1, FIFO holds `DEPTH` entries
- `empty` output 1, FIFO holds 0 entries
- `count` output AW+1, current occupancy, 0..`DEPTH`
- `overflow` output 1, sticky: a write was dropped
- `timeout` output 1, sticky: a launch was abandoned

## Operation
- Storage: `DEPTH`×8 register array with `AW`-bit read and write pointers and an (AW+1)-bit count.
  - Pointers wrap modulo `DEPTH`.
  - `full` = (count == `DEPTH`); `empty` = (count == 0).
- Write: `wr_en` && !`full` stores `wr_data` at the write pointer and advances the pointer.
  - `wr_en` && `full` drops the byte, sets `overflow`, and leaves the pointer unchanged.
  - A write while `full` is rejected even if a pop happens in the same cycle.
- Simultaneous write and pop (not full): count is unchanged and both pointers advance.
- `busy_s`: `uart_busy` through a two-flop synchroniser; this is the only use of `uart_busy`.
- Launch FSM:
  - IDLE, exit condition: !`empty` && !`busy_s`.
    - Load `uart_data` from the head entry, pop the FIFO, clear the timeout counter, go to LAUNCH.
  - LAUNCH: `uart_send`=1 and `uart_data` held constant.
    - `busy_s`=1 → WAIT.
    - Timeout counter reaches `LAUNCH_TO`-1 → set `timeout`, go to IDLE. The byte is lost.
  - WAIT: `uart_send`=0.
    - `busy_s`=0 → IDLE.
- `uart_data` changes only on the IDLE→LAUNCH transition.
- `clr_err` clears both sticky flags. If `clr_err` coincides with a new overflow or timeout event, the set wins.
- Reset (asynchronous, at any time, including mid-LAUNCH or mid-WAIT):
  - FSM→IDLE, pointers and count → 0, synchroniser flops → 0, timeout counter → 0.
  - A byte already accepted by the transmitter completes on the line; the block does not track it.

## Timing
- Reset values:
  - `uart_send`=0, `uart_data`=8'h00
  - `full`=0, `empty`=1, `count`=0
  - `overflow`=0, `timeout`=0
- Write → `count`/`empty` update: next `clk` edge.
- Write into an empty FIFO with `busy_s`=0:
  - `uart_send` rises 2 cycles after the `wr_en` cycle (1 for the FIFO write, 1 for the IDLE→LAUNCH register).
- `uart_busy` rise → `busy_s` high after 2 edges → WAIT on the following edge. `uart_send` is therefore held at least 3 `clk` cycles after `busy` rises.
- Held-high requirement: `uart_send` must stay high at least one full `tick` period; the busy acknowledge guarantees this.
  - `LAUNCH_TO` must exceed 2 `tick` periods in `clk` cycles.
- Back-to-back bytes: the next launch starts ≥1 cycle after `busy_s` falls. There is no launch while `busy_s`=1.
- `count` includes neither the byte in LAUNCH/WAIT nor the byte on the line.

## Test plan
- Reset with `wr_en` idle → `empty`=1, `count`=0, `uart_send`=0, `uart_data`=0; assert reset mid-LAUNCH → all of these return immediately, asynchronously.
- Write 8'hA5 with a transmitter model whose `busy` rises 5 cycles after `send` and lasts 40 cycles → `uart_send` high from cycle 2 until 3 cycles after `busy` rises. `uart_data`=8'hA5 throughout. `count` returns to 0.
- Burst-write 17 bytes 0x00..0x10 with `busy` stuck high (DEPTH=16):
  - 0x00 launches. 0x01..0x10 fill the FIFO: `full`=1, `count`=16.
  - One further write → `overflow`=1 and `count` stays 16.
  - Release `busy` → bytes drain in order 0x01..0x10.
- Transmitter never raises `busy` with `LAUNCH_TO`=64 → `uart_send` high for exactly 64 cycles, `timeout`=1, FSM returns to IDLE and launches the next byte.
- Write and pop in the same cycle at `count`=3 → `count` stays 3. Assert `clr_err` in the same cycle as an overflow event → `overflow` remains 1.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO and launch state machine between the CPU store path and the baud-rate UART.
// Bytes are held stable on uart_data until the transmitter's synchronised busy acknowledges them.
module uart_tx_fifo #(
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int LAUNCH_TO = 4096
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          clr_err,
    input  logic          uart_busy,
    output logic          uart_send,
    output logic [7:0]    uart_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          timeout
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LAUNCH = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;

    localparam int            TW      = (LAUNCH_TO > 2) ? $clog2(LAUNCH_TO) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(LAUNCH_TO - 1);
    localparam logic [AW:0]   FULL_C  = (AW + 1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [AW:0]   count_q, count_d;
    logic [1:0]    state_q, state_d;
    logic [TW-1:0] toCnt_q, toCnt_d;
    logic [7:0]    data_q, data_d;
    logic          syncA_q, busyS_q;
    logic          overflow_q, overflow_d;
    logic          timeout_q, timeout_d;
    logic          pushOk, pop, toEvent;

    assign full      = (count_q == FULL_C);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign uart_send = (state_q == LAUNCH);
    assign uart_data = data_q;
    assign overflow  = overflow_q;
    assign timeout   = timeout_q;

    // A write while full is rejected even if a pop frees a slot in the same cycle.
    assign pushOk = wr_en && !full;
    assign pop    = (state_q == IDLE) && !empty && !busyS_q;

    always_comb begin
        state_d = state_q;
        toCnt_d = toCnt_q;
        data_d  = data_q;
        toEvent = 1'b0;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    data_d  = mem_q[rdPtr_q];
                    toCnt_d = '0;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                if (busyS_q) begin
                    state_d = WAIT;
                end else if (toCnt_q == TO_LAST) begin
                    toEvent = 1'b1;
                    state_d = IDLE;
                end else begin
                    toCnt_d = toCnt_q + TW'(1);
                end
            end
            WAIT: begin
                if (!busyS_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wrPtr_d    = pushOk ? wrPtr_q + AW'(1) : wrPtr_q;
        rdPtr_d    = pop ? rdPtr_q + AW'(1) : rdPtr_q;
        count_d    = count_q + (AW + 1)'(pushOk) - (AW + 1)'(pop);
        overflow_d = (wr_en && full) ? 1'b1 : (clr_err ? 1'b0 : overflow_q);
        timeout_d  = toEvent ? 1'b1 : (clr_err ? 1'b0 : timeout_q);
    end

    always_ff @(posedge clk) begin
        if (pushOk) begin
            mem_q[wrPtr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            state_q    <= IDLE;
            toCnt_q    <= '0;
            data_q     <= 8'h00;
            syncA_q    <= 1'b0;
            busyS_q    <= 1'b0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            toCnt_q    <= toCnt_d;
            data_q     <= data_d;
            syncA_q    <= uart_busy;
            busyS_q    <= syncA_q;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: reset, single launch, burst/overflow, launch timeout,
// coincident write and pop, and asynchronous reset during a launch.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       clr_err;
    logic       uart_busy;
    logic       uart_send;
    logic [7:0] uart_data;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       timeout;

    logic       txManual = 1'b0;
    logic       manualBusy = 1'b0;
    logic       autoBusy;
    logic       txAck = 1'b1;
    int         busyDelay = 5;
    int         busyLen = 40;
    logic [7:0] sentQ [$];

    int         checkCount = 0;
    int         passCount = 0;

    uart_tx_fifo #(.DEPTH(16), .AW(4), .LAUNCH_TO(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .clr_err   (clr_err),
        .uart_busy (uart_busy),
        .uart_send (uart_send),
        .uart_data (uart_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    assign uart_busy = txManual ? manualBusy : autoBusy;

    // Transmitter model: latch the presented byte, raise busy after a delay, hold it, drop it.
    initial begin
        autoBusy = 1'b0;
        forever begin
            @(negedge clk);
            if (!txManual && txAck && uart_send && !autoBusy) begin
                sentQ.push_back(uart_data);
                repeat (busyDelay) @(negedge clk);
                autoBusy = 1'b1;
                repeat (busyLen) @(negedge clk);
                autoBusy = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic [7:0] data, input logic clr);
        wr_en   = wr;
        wr_data = data;
        clr_err = clr;
        @(negedge clk);
        wr_en   = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic waitQuiet(input string tag);
        int n = 0;
        while ((uart_busy || uart_send || autoBusy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 32'(n < 400), 32'd1);
        repeat (5) @(negedge clk);
    endtask

    task automatic waitSent(input string tag, input int want);
        int n = 0;
        while (sentQ.size() < want && n < 800) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 32'(sentQ.size()), 32'(want));
    endtask

    initial begin
        int cyc;
        int hi;
        int bad;
        logic [7:0] got;

        reset   = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        clr_err = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        checkOutput("rst_empty", 32'(empty), 32'd1);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_send", 32'(uart_send), 32'd0);
        checkOutput("rst_data", 32'(uart_data), 32'h00);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        checkOutput("rst_timeout", 32'(timeout), 32'd0);

        // Single byte against a transmitter acknowledging 5 cycles after send, busy for 40.
        applyStimulus(1'b1, 8'hA5, 1'b0);
        checkOutput("a5_count_after_write", 32'(count), 32'd1);
        checkOutput("a5_send_not_yet", 32'(uart_send), 32'd0);
        cyc = 0;
        while (!uart_send && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("a5_send_latency", 32'(cyc), 32'd1);
        hi = 0;
        bad = 0;
        while (uart_send && hi < 200) begin
            if (uart_data !== 8'hA5) bad++;
            hi++;
            @(negedge clk);
        end
        checkOutput("a5_send_high_cycles", 32'(hi), 32'd8);
        checkOutput("a5_data_unstable", 32'(bad), 32'd0);
        checkOutput("a5_count_back_to_0", 32'(count), 32'd0);
        waitQuiet("a5_quiet");
        checkOutput("a5_sent_count", 32'(sentQ.size()), 32'd1);
        got = (sentQ.size() > 0) ? sentQ[0] : 8'hFF;
        checkOutput("a5_sent_byte", 32'(got), 32'hA5);

        // Burst of 17 bytes; 0x00 launches and 0x01..0x10 fill the FIFO.
        txManual   = 1'b1;
        manualBusy = 1'b0;
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0);
        end
        checkOutput("burst_count_16", 32'(count), 32'd16);
        checkOutput("burst_full", 32'(full), 32'd1);
        checkOutput("burst_launching", 32'(uart_send), 32'd1);
        checkOutput("burst_data_00", 32'(uart_data), 32'h00);
        manualBusy = 1'b1;
        applyStimulus(1'b1, 8'h11, 1'b1);
        checkOutput("ovf_set_beats_clear", 32'(overflow), 32'd1);
        checkOutput("ovf_count_held", 32'(count), 32'd16);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("ovf_cleared", 32'(overflow), 32'd0);
        applyStimulus(1'b1, 8'h12, 1'b0);
        checkOutput("ovf_set_again", 32'(overflow), 32'd1);
        checkOutput("ovf_count_still_16", 32'(count), 32'd16);
        cyc = 0;
        while (uart_send && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("burst_enter_wait", 32'(uart_send), 32'd0);
        checkOutput("burst_no_launch_while_busy", 32'(count), 32'd16);
        sentQ.delete();
        busyDelay = 2;
        busyLen   = 4;
        txAck     = 1'b1;
        txManual  = 1'b0;
        waitSent("drain_size", 16);
        for (int i = 0; i < 16; i++) begin
            got = (i < sentQ.size()) ? sentQ[i] : 8'hFF;
            checkOutput("drain_byte", 32'(got), 32'(i + 1));
        end
        waitQuiet("drain_quiet");
        checkOutput("drain_empty", 32'(empty), 32'd1);

        // Transmitter ignores send: launch is abandoned after 64 cycles, next byte goes out.
        txAck = 1'b0;
        applyStimulus(1'b1, 8'h3C, 1'b0);
        applyStimulus(1'b1, 8'h4D, 1'b0);
        hi = 0;
        while (uart_send && hi < 200) begin
            hi++;
            @(negedge clk);
        end
        checkOutput("to_send_high_cycles", 32'(hi), 32'd64);
        checkOutput("to_flag_set", 32'(timeout), 32'd1);
        checkOutput("to_count_pending", 32'(count), 32'd1);
        sentQ.delete();
        txAck = 1'b1;
        @(negedge clk);
        checkOutput("to_relaunch_send", 32'(uart_send), 32'd1);
        checkOutput("to_relaunch_data", 32'(uart_data), 32'h4D);
        waitSent("to_relaunch_sent", 1);
        got = (sentQ.size() > 0) ? sentQ[0] : 8'hFF;
        checkOutput("to_relaunch_byte", 32'(got), 32'h4D);
        checkOutput("to_flag_sticky", 32'(timeout), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("to_flag_cleared", 32'(timeout), 32'd0);
        waitQuiet("to_quiet");

        // Write coinciding with the pop at count 3 leaves count unchanged.
        txManual   = 1'b1;
        manualBusy = 1'b0;
        applyStimulus(1'b1, 8'h50, 1'b0);
        @(negedge clk);
        checkOutput("sim_launch_50", 32'(uart_data), 32'h50);
        manualBusy = 1'b1;
        cyc = 0;
        while (uart_send && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        applyStimulus(1'b1, 8'h51, 1'b0);
        applyStimulus(1'b1, 8'h52, 1'b0);
        applyStimulus(1'b1, 8'h53, 1'b0);
        checkOutput("sim_count_3", 32'(count), 32'd3);
        manualBusy = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("sim_no_pop_yet", 32'(uart_send), 32'd0);
        applyStimulus(1'b1, 8'h54, 1'b0);
        checkOutput("sim_count_stays_3", 32'(count), 32'd3);
        checkOutput("sim_popped_send", 32'(uart_send), 32'd1);
        checkOutput("sim_popped_data", 32'(uart_data), 32'h51);
        sentQ.delete();
        busyDelay = 2;
        busyLen   = 4;
        txAck     = 1'b1;
        txManual  = 1'b0;
        waitSent("sim_drain_size", 4);
        for (int i = 0; i < 4; i++) begin
            got = (i < sentQ.size()) ? sentQ[i] : 8'hFF;
            checkOutput("sim_drain_byte", 32'(got), 32'(8'h51 + i));
        end
        waitQuiet("sim_quiet");

        // Asynchronous reset in the middle of a launch.
        txAck = 1'b0;
        applyStimulus(1'b1, 8'h77, 1'b0);
        applyStimulus(1'b1, 8'h78, 1'b0);
        checkOutput("arst_pre_send", 32'(uart_send), 32'd1);
        checkOutput("arst_pre_count", 32'(count), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("arst_send", 32'(uart_send), 32'd0);
        checkOutput("arst_data", 32'(uart_data), 32'h00);
        checkOutput("arst_count", 32'(count), 32'd0);
        checkOutput("arst_empty", 32'(empty), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("arst_stays_idle", 32'(uart_send), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
